// File: rtl/gfx_pkg.sv
// gfx_pkg: shared graphics widths, framebuffer geometry, arbiter states and clog2
package gfx_pkg;
    localparam int COORD_W   = 10;
    localparam int COLOR_W   = 12;
    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/pixel_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search of a request vector from a start index
module rr_pick
    import gfx_pkg::*;
#(
    parameter int N = 4,
    localparam int SW = clog2(N)
)(
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_start,
    input  logic [N-1:0]  i_excl,
    output logic          o_found,
    output logic [SW-1:0] o_idx
);
    logic [N-1:0] w_cand;

    assign w_cand = i_req & ~i_excl;

    // scan offsets high to low so the candidate nearest the start pointer wins
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_cand[(int'(i_start) + k) % N]) begin
                o_found = 1'b1;
                o_idx   = SW'((int'(i_start) + k) % N);
            end
        end
    end
endmodule

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: round-robin, burst-limited sharing of the framebuffer pixel port
// Optional per-requester beat/stall counters are built when ARB_STATS_EN is defined.
module pixel_write_arbiter
    import gfx_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 8,
    parameter int CW        = COLOR_W,
    localparam int SW = clog2(N),
    localparam int BW = clog2(MAX_BURST + 1)
)(
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [N-1:0]          req_rts,
    output logic [N-1:0]          req_rtr,
    input  logic [N*COORD_W-1:0]  req_x,
    input  logic [N*COORD_W-1:0]  req_y,
    input  logic [N*CW-1:0]       req_color,
    output logic                  out_rts,
    input  logic                  out_rtr,
    output logic [COORD_W-1:0]    out_x,
    output logic [COORD_W-1:0]    out_y,
    output logic [CW-1:0]         out_color,
    output logic [SW-1:0]         out_src,
`ifdef ARB_STATS_EN
    input  logic                  stat_clr,
    output logic [N*16-1:0]       stat_beats,
    output logic [N*16-1:0]       stat_stalls,
`endif
    output logic                  busy
);
    arb_state_t         r_state, w_state_nxt;
    logic [SW-1:0]      r_grant, w_grant_nxt, r_rr_ptr, w_rr_nxt;
    logic [SW-1:0]      w_grant_inc, w_start, w_pick_idx;
    logic [BW-1:0]      r_burst_cnt, w_burst_nxt;
    logic [N-1:0]       w_grant_oh, w_excl;
    logic               w_out_free, w_acc, w_release, w_pick_found, w_grant_rts;
    logic               r_out_rts;
    logic [COORD_W-1:0] r_out_x, r_out_y;
    logic [CW-1:0]      r_out_color;
    logic [SW-1:0]      r_out_src;

    assign w_grant_oh  = {{(N-1){1'b0}}, 1'b1} << r_grant;
    assign w_grant_rts = req_rts[r_grant];
    assign w_out_free  = !r_out_rts || out_rtr;
    assign w_acc       = (r_state == ARB_GRANT) && w_grant_rts && w_out_free;
    assign w_release   = (r_state == ARB_GRANT) &&
                         (!w_grant_rts || (w_acc && r_burst_cnt == BW'(MAX_BURST - 1)));
    assign w_grant_inc = (r_grant == SW'(N - 1)) ? '0 : r_grant + 1'b1;
    assign w_start     = (r_state == ARB_IDLE) ? r_rr_ptr : w_grant_inc;
    assign w_excl      = (r_state == ARB_GRANT && !w_grant_rts) ? w_grant_oh : '0;
    assign req_rtr     = (r_state == ARB_GRANT && w_out_free) ? w_grant_oh : '0;
    assign busy        = (r_state == ARB_GRANT) || r_out_rts;
    assign out_rts     = r_out_rts;
    assign out_x       = r_out_x;
    assign out_y       = r_out_y;
    assign out_color   = r_out_color;
    assign out_src     = r_out_src;

    rr_pick #(.N(N)) u_pick (
        .i_req   (req_rts),
        .i_start (w_start),
        .i_excl  (w_excl),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    // next grant: first pick out of IDLE, or zero-bubble handover on release
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_burst_nxt = w_acc ? r_burst_cnt + 1'b1 : r_burst_cnt;
        if (r_state == ARB_IDLE && w_pick_found) begin
            w_state_nxt = ARB_GRANT;
            w_grant_nxt = w_pick_idx;
            w_burst_nxt = '0;
        end else if (w_release) begin
            w_rr_nxt    = w_grant_inc;
            w_state_nxt = w_pick_found ? ARB_GRANT : ARB_IDLE;
            w_grant_nxt = w_pick_found ? w_pick_idx : r_grant;
            w_burst_nxt = '0;
        end
    end

    // arbitration state registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // output stage: load the granted lane on accept, hold under backpressure
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_out_rts   <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_color <= '0;
            r_out_src   <= '0;
        end else if (w_acc) begin
            r_out_rts   <= 1'b1;
            r_out_x     <= req_x[r_grant*COORD_W +: COORD_W];
            r_out_y     <= req_y[r_grant*COORD_W +: COORD_W];
            r_out_color <= req_color[r_grant*CW +: CW];
            r_out_src   <= r_grant;
        end else if (out_rtr) begin
            r_out_rts   <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    for (genvar i = 0; i < N; i++) begin : g_stat
        logic [15:0] r_beats, r_stalls;
        // saturating per-requester beat and stall counters, clear wins over count
        always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
                r_beats  <= '0;
                r_stalls <= '0;
            end else if (stat_clr) begin
                r_beats  <= '0;
                r_stalls <= '0;
            end else begin
                if (req_rts[i] && req_rtr[i] && r_beats != 16'hffff)
                    r_beats <= r_beats + 1'b1;
                if (req_rts[i] && !req_rtr[i] && r_stalls != 16'hffff)
                    r_stalls <= r_stalls + 1'b1;
            end
        end
        assign stat_beats[i*16 +: 16]  = r_beats;
        assign stat_stalls[i*16 +: 16] = r_stalls;
    end
`endif
endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
Shares the single framebuffer pixel-write port between N shape drawers (circle, line, rect, fill), each emitting pixel beats on an rts/rtr handshake. Round-robin grant with bounded burst lock: a drawer keeps the port for consecutive beats, then yields. Output is one registered stage that feeds the framebuffer writer.

Parameters:
N, 4, number of requesting drawers (2..8)
MAX_BURST, 8, max beats accepted per grant before forced release (1..256)
CW, 12, color width (4:4:4 RGB)

Ports:
clk  in  1  system clock
rst_  in  1  asynchronous active-low reset
req_rts  in  N  requester i has a valid pixel
req_rtr  out  N  arbiter accepts requester i's pixel this cycle
req_x  in  N*10  packed x, requester i at [10i+9:10i]
req_y  in  N*10  packed y, same packing
req_color  in  N*CW  packed color
out_rts  out  1  output pixel valid
out_rtr  in  1  framebuffer writer ready
out_x  out  10  pixel x
out_y  out  10  pixel y
out_color  out  CW  pixel color
out_src  out  clog2(N)  index of requester that produced the beat
busy  out  1  state==GRANT or out_rts

Behaviour:
- Reset (async, rst_=0): state=IDLE, grant=0, rr_ptr=0, burst_cnt=0, out_rts=0, out_x/out_y/out_color/out_src=0, req_rtr=0. Any held beat is discarded. Deassertion is sampled on the next clk rising edge.
- States: IDLE, GRANT.
- IDLE: if |req_rts, pick the first i with req_rts[i]=1, searching from rr_ptr upward mod N. Register grant=i, burst_cnt=0, go to GRANT. There is a 1-cycle arbitration bubble out of IDLE.
- Output register: out_free = !out_rts || out_rtr.
- req_rtr[i] = (state==GRANT) && (grant==i) && out_free. It is combinational, and every other bit is 0.
- Accepted beat: req_rts[grant] && req_rtr[grant]. On that edge, out_x/out_y/out_color/out_src are loaded from the granted lane, out_rts=1, burst_cnt++.
- Latency: accepted beat appears on out_* 1 cycle later. Throughput is 1 beat/cycle while out_rtr=1.
- out_rts falls only on an out_rtr=1 edge with no new accepted beat. out_* stay stable while out_rts=1 and out_rtr=0.
- Release from GRANT happens on the first edge where either:
  (a) req_rts[grant]=0, or
  (b) an accepted beat makes burst_cnt reach MAX_BURST.
- On release: rr_ptr=(grant+1) mod N. Search the current req_rts from rr_ptr; the old grant is checked last and is ineligible in case (a).
  - If a candidate is found: grant=candidate, burst_cnt=0, stay in GRANT (zero bubble).
  - If none is found: go to IDLE.
- A sole requester hitting MAX_BURST is regranted immediately with a fresh burst_cnt. No lost cycle and no starvation.
- Requester contract: req_x/y/color stable while req_rts=1 and not accepted. The arbiter does not check this.
- Simultaneous requests: the winner is decided by rr_ptr only. Fixed index never wins.
- burst_cnt width is clog2(MAX_BURST+1), with no wrap inside a grant.

Optional Feature:
ARB_STATS_EN
- Defined: adds per-requester 16-bit saturating counters.
  - beats_i increments on each accepted beat from i.
  - stall_i increments on each cycle req_rts[i]=1 and req_rtr[i]=0.
  - Exported as packed outputs stat_beats[N*16] and stat_stalls[N*16], plus input stat_clr (synchronous clear of both counters, priority over increment).
  - Counters reset to 0 on rst_.
- Undefined: counters, stat_* ports and stat_clr are absent. Handshake behaviour is identical.

Decomposition:
- Shared package gfx_pkg: COORD_W=10, COLOR_W=12, FB_WIDTH=640, FB_HEIGHT=480, state encoding (ARB_IDLE, ARB_GRANT), clog2 function.
- Sub-module rr_pick (combinational): inputs req vector, start pointer and exclude mask; outputs found and index. Used by both the IDLE and release paths.

Test Plan:
1. Single requester: req_rts=4'b0001, x=100,y=100,color=12'habc, out_rtr=1. Expect grant after 1 bubble, then one beat per cycle. Expect the output to lag the input by 1 cycle with out_src=0. After 8 beats, regrant with no gap.
2. Round-robin: all 4 rts held, MAX_BURST=8, out_rtr=1. Expect bursts of 8 in order src 0,1,2,3,0, with no idle cycles between bursts.
3. Early release: req1 drops rts after 3 beats while req2 is pending. Expect src 2 on the next accepted beat with no bubble, and rr_ptr=2.
4. Backpressure: out_rtr=0 for 5 cycles mid-burst. Expect out_* to hold, req_rtr=0, and burst_cnt frozen. Resume with no lost or duplicated beat (scoreboard x,y sequence).
5. Reset mid-burst: pull rst_ low between edges with out_rts=1. Expect out_rts=0 and req_rtr=0 immediately. After release, arbitration restarts at rr_ptr=0.
6. ARB_STATS_EN: req0 and req1 contend for 20 cycles. Check beats_0+beats_1 equals the accepted count, and stall counts match the cycles spent waiting. Check stat_clr zeroes both counters.
